// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/sequencer: opcode and funct encodings,
// the reset-time instruction word, and the fetch state enumeration.
// No ports; imported by instr_fetch_unit and next_pc_sel.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_STALL = 6'b000110;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // IR contents after reset: opcode field is OP_NOP, everything else zero.
  localparam logic [31:0] NOP_WORD = 32'hFC00_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_STALL
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC mux and branch adder (jr > j/jal > taken branch > pc+4).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when next_pc is loaded.
// Ports: pc_plus4, IR fields (opcode/funct/imm/target), rs_data, decoder strobes, zero -> next_pc.
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              jump,
  input  logic              branch_on_eq,
  input  logic              branch_on_neq,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic              is_jr;
  logic              br_taken;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] jr_addr;
  logic [ADDR_W-1:0] j_addr;

  assign is_jr    = jump && (opcode == OP_RTYPE) && (funct == FUNCT_JR);
  // Both strobes high is legal: whichever condition matches zero wins.
  assign br_taken = (branch_on_eq && zero) || (branch_on_neq && !zero);

  // Sign-extended word offset; the add below wraps modulo 2^ADDR_W.
  assign br_offset = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  // Register targets are forced onto a word boundary.
  assign jr_addr   = rs_data & ~ADDR_W'(3);
  // Region jump keeps the top nibble of the sequential address.
  assign j_addr    = {pc_plus4[ADDR_W-1:28], target, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (is_jr) begin
      next_pc = jr_addr;
    end else if (jump) begin
      next_pc = j_addr;
    end else if (br_taken) begin
      next_pc = pc_plus4 + br_offset;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch/sequencer; requests imem, holds IR, drives decode fields, computes next PC.
// Latency: 3 cycles per instruction with zero-wait ack (FETCH -> DECODE -> EXEC); STALL waits for resume.
// Backpressure: imem_req held until imem_ack; with FETCH_TIMEOUT_EN defined a 16-cycle watchdog
//   sets sticky fetch_err, drops imem_req for one cycle and re-issues the same pc.
// Ports: clk/rst (sync, active-low); imem_req/addr/ack/rdata; IR fields opcode..target;
//   instr_valid; zero, branch_on_eq/neq, jump, rs_data, resume; pc, pc_plus4, stalled, fetch_err.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic [25:0]       target,
  output logic              instr_valid,
  input  logic              zero,
  input  logic              branch_on_eq,
  input  logic              branch_on_neq,
  input  logic              jump,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              stalled,
  output logic              fetch_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q;
  logic              ir_load;
  logic [ADDR_W-1:0] next_pc;
  logic              req_block;   // suppresses the request for the retry gap

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign imem_addr = pc_q;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign target = ir_q[25:0];

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .opcode        (opcode),
    .funct         (funct),
    .imm           (imm),
    .target        (target),
    .rs_data       (rs_data),
    .jump          (jump),
    .branch_on_eq  (branch_on_eq),
    .branch_on_neq (branch_on_neq),
    .zero          (zero),
    .next_pc       (next_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             drop_q;
  logic             err_q;
  logic             fetch_wait;
  logic             to_hit;

  // A cycle counts toward the timeout only while the request is actually
  // on the bus and unanswered; anything else (ack, gap, other state) clears it.
  assign fetch_wait = (state_q == ST_FETCH) && !drop_q && !imem_ack;
  assign to_hit     = fetch_wait && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (fetch_wait && !to_hit) ? to_cnt_q + CNT_W'(1) : '0;
      drop_q   <= to_hit;
      if (to_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign req_block = drop_q;
  assign fetch_err = err_q;
`else
  assign req_block = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_load     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    stalled     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = !req_block;
        // An ack during the retry gap has no request to answer.
        if (!req_block && imem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        instr_valid = 1'b1;
        state_d     = (opcode == OP_STALL) ? ST_STALL : ST_EXEC;
      end
      ST_EXEC: begin
        pc_d    = next_pc;
        state_d = ST_FETCH;
      end
      ST_STALL: begin
        stalled = 1'b1;
        if (resume) begin
          pc_d    = pc_plus4;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ir_load) begin
        ir_q <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, branches, jumps, stall/resume,
// reset mid-fetch with late ack, and the fetch watchdog when FETCH_TIMEOUT_EN is defined.
// Expected values are hand-computed constants.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        instr_valid;
  logic        zero = 1'b0;
  logic        branch_on_eq = 1'b0;
  logic        branch_on_neq = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] rs_data = '0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stalled;
  logic        fetch_err;

  int n_cmp = 0;
  int n_mis = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .funct         (funct),
    .imm           (imm),
    .target        (target),
    .instr_valid   (instr_valid),
    .zero          (zero),
    .branch_on_eq  (branch_on_eq),
    .branch_on_neq (branch_on_neq),
    .jump          (jump),
    .rs_data       (rs_data),
    .resume        (resume),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .stalled       (stalled),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (imem_req !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, imem_req}, 32'h1);
  endtask

  // Called in FETCH; acks immediately, drives strobes for EXEC, checks resulting pc.
  task automatic run_instr(input string tag, input logic [31:0] word, input logic j,
                           input logic beq, input logic bne, input logic z,
                           input logic [31:0] rsd, input logic [31:0] exp_pc);
    wait_req({tag, "_req"});
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack      = 1'b0;
    jump          = j;
    branch_on_eq  = beq;
    branch_on_neq = bne;
    zero          = z;
    rs_data       = rsd;
    chk({tag, "_vld"}, {31'b0, instr_valid}, 32'h1);
    tick();
    chk({tag, "_vld_exec"}, {31'b0, instr_valid}, 32'h0);
    tick();
    jump          = 1'b0;
    branch_on_eq  = 1'b0;
    branch_on_neq = 1'b0;
    zero          = 1'b0;
    rs_data       = '0;
    chk({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int hi;
    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_vld", {31'b0, instr_valid}, 32'h0);
    chk("rst_stall", {31'b0, stalled}, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_op", {26'b0, opcode}, 32'h3F);
    rst = 1'b1;

    // addi fetched with ack on the 2nd FETCH cycle
    tick();
    chk("f1_req", {31'b0, imem_req}, 32'h1);
    chk("f1_addr", imem_addr, 32'h0);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h2001_0005;
    tick();
    imem_ack = 1'b0;
    chk("addi_vld", {31'b0, instr_valid}, 32'h1);
    chk("addi_op", {26'b0, opcode}, 32'h08);
    chk("addi_rt", {27'b0, rt}, 32'h1);
    chk("addi_imm", {16'b0, imm}, 32'h5);
    chk("addi_pc_dec", pc, 32'h0);
    tick();
    chk("addi_vld_exec", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("addi_pc", pc, 32'h4);
    chk("addi_next_addr", imem_addr, 32'h4);

    // Branches, jumps, priority and wrap
    run_instr("j_to_10",    32'h0800_0004, 1, 0, 0, 0, 32'h0,         32'h0000_0010);
    run_instr("beq_taken",  32'h1000_FFFE, 0, 1, 0, 1, 32'h0,         32'h0000_000C);
    run_instr("nop",        32'hFC00_0000, 0, 0, 0, 0, 32'h0,         32'h0000_0010);
    run_instr("beq_not",    32'h1000_FFFE, 0, 1, 0, 0, 32'h0,         32'h0000_0014);
    run_instr("jr_far",     32'h0000_0008, 1, 0, 0, 0, 32'h1000_0040, 32'h1000_0040);
    run_instr("j_region",   32'h0800_0100, 1, 0, 0, 0, 32'h0,         32'h1000_0400);
    run_instr("jr_align",   32'h0000_0008, 1, 0, 0, 0, 32'h0000_0203, 32'h0000_0200);
    run_instr("both_br",    32'h1000_0004, 0, 1, 1, 0, 32'h0,         32'h0000_0214);
    run_instr("jump_prio",  32'h0800_0010, 1, 1, 0, 1, 32'h0,         32'h0000_0040);
    run_instr("unknown_op", 32'hE000_0000, 0, 0, 0, 0, 32'h0,         32'h0000_0044);
    run_instr("jr_top",     32'h0000_0008, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    run_instr("wrap_nop",   32'hFC00_0000, 0, 0, 0, 0, 32'h0,         32'h0000_0000);
    run_instr("j_to_20",    32'h0800_0008, 1, 0, 0, 0, 32'h0,         32'h0000_0020);

    // Stall: held for 10 cycles, stray ack ignored, then resume
    wait_req("stall_req");
    imem_ack   = 1'b1;
    imem_rdata = 32'h1800_0000;
    tick();
    imem_ack = 1'b0;
    chk("stall_vld", {31'b0, instr_valid}, 32'h1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_flag", {31'b0, stalled}, 32'h1);
      chk("stall_pc", pc, 32'h20);
      imem_ack   = (i == 3);
      imem_rdata = 32'h0800_0004;
      tick();
    end
    imem_ack = 1'b0;
    chk("stall_op", {26'b0, opcode}, 32'h06);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_stall", {31'b0, stalled}, 32'h0);
    chk("resume_pc", pc, 32'h24);
    chk("resume_req", {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h24);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_ignored", pc, 32'h24);

    // Reset mid-FETCH, then a late ack while in IDLE
    chk("pre_rst_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b0;
    tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    chk("mid_rst_op", {26'b0, opcode}, 32'h3F);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0800_0004;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_ir", {26'b0, opcode}, 32'h3F);
    chk("late_ack_req", {31'b0, imem_req}, 32'h1);
    tick();
    chk("late_ack_vld", {31'b0, instr_valid}, 32'h0);

    // Watchdog: fresh FETCH with no ack
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("to_err_start", {31'b0, fetch_err}, 32'h0);
    hi = 0;
    while (imem_req === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    chk("to_req_cycles", hi, 32'd16);
    chk("to_err_set", {31'b0, fetch_err}, 32'h1);
    tick();
    chk("to_reissue_req", {31'b0, imem_req}, 32'h1);
    chk("to_reissue_addr", imem_addr, 32'h0);
    run_instr("to_after", 32'hFC00_0000, 0, 0, 0, 0, 32'h0, 32'h4);
    chk("to_err_sticky", {31'b0, fetch_err}, 32'h1);
`else
    chk("no_to_req_cycles", hi, 32'd40);
    chk("no_to_err", {31'b0, fetch_err}, 32'h0);
    run_instr("no_to_after", 32'hFC00_0000, 0, 0, 0, 0, 32'h0, 32'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
